student_or16_arbiter: RTL and testbench
=======================================

# student_or16_arbiter

Shares one `student_or16` datapath among `NREQ` requesters, with a round-robin grant and a valid/ready handshake on every requester and on the single result port. It latches the granted operand pair and evaluates it on the shared OR16 unit. It then holds the result, tagged with the requester id and a nonzero flag, until it is consumed. All logic operations are built from the project's gate modules (`student_or`, `student_or16`, `student_or8way`); built-in OR operators are not permitted.

## Interface
- `NREQ`, default 4: number of requesters; legal values are 2, 4 and 8.
- `IDW`, default 2: id width; must equal log2(`NREQ`).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i set means requester i offers an operand pair.
- `req_a`  in  16*NREQ  operand A; requester i uses bits [16i+15:16i].
- `req_b`  in  16*NREQ  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot or zero; bit i set means requester i is accepted this cycle.
- `rsp_valid`  out  1  result is available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  16  latched `a OR b` of the granted pair.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `rsp_nz`  out  1  1 when `rsp_data` is nonzero.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid` is set, grant one requester, latch its `a`/`b` and id, then go to EXEC.
  - EXEC: the shared `student_or16` evaluates the latched operands. `rsp_data` is registered, `rsp_nz` is computed (`student_or8way` on each byte, combined with `student_or`). Go to RESP.
  - RESP: `rsp_valid`=1. When `rsp_ready`=1, go to IDLE; otherwise hold.
- Arbitration: round-robin with priority pointer `ptr` (IDW bits).
  - Grant the first set `req_valid` bit, searching from index `ptr` upward with wrap-around modulo `NREQ`.
  - On a grant to index g, set `ptr` = (g+1) mod `NREQ`.
  - `ptr` is unchanged when no grant occurs.
- `req_ready` is combinational from `req_valid`, `ptr` and state.
  - It is nonzero only in IDLE, and only the granted bit is set.
  - `req_ready[i]` never rises unless `req_valid[i]` is high.
- A handshake on requester i is `req_valid[i] & req_ready[i]`. Operands are sampled on that edge only; changes to `req_a`/`req_b` afterwards have no effect on the result.
- There is exactly one shared OR16 instance; operand muxing uses the latched registers, not live inputs.
- Outputs are stable while `rsp_valid`=1 and `rsp_ready`=0: `rsp_data`, `rsp_id` and `rsp_nz` do not change.
- Dropping `req_valid` before a grant is legal. That requester is simply not granted.

## Timing
- Reset values:
  - State is IDLE and `ptr`=0.
  - `req_ready` is all zeros in the reset cycle.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_nz`=0, `busy`=0.
- Latency: a handshake at edge T gives state EXEC during cycle T+1 and `rsp_valid`=1 from cycle T+2.
- Throughput: with `rsp_ready` tied high, one accept every 3 cycles (accept T, EXEC T+1, RESP/consume T+2, next accept T+3).
- Backpressure: RESP holds indefinitely, and `req_ready` stays 0 throughout.
- Simultaneous requests: all `req_valid` set in IDLE with `ptr`=k grants k.
- `ptr` wrap: a grant to index `NREQ`-1 sets `ptr`=0.
- Reset mid-operation: `reset` in EXEC or RESP aborts the transaction.
  - `rsp_valid` is 0 on the next cycle and the pending result is lost.
  - `ptr` returns to 0.
- `reset` has priority over any simultaneous handshake. A request presented in the reset cycle is not accepted.

## Test plan
- Single request: reset, then requester 2 with a=16'h00F0, b=16'h0F00. Expect `req_ready`=4'b0100 in the same cycle, then 2 cycles later `rsp_valid`=1, `rsp_data`=16'h0FF0, `rsp_id`=2, `rsp_nz`=1.
- Zero operands: a=b=16'h0000 on requester 0. Expect `rsp_data`=0, `rsp_nz`=0.
- Round-robin fairness: all four requesters valid continuously with `rsp_ready`=1. Expect grant order 0,1,2,3,0 with accepts 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises. Expect outputs held, `req_ready`=0 and `busy`=1 throughout, and the next accept only in the cycle after `rsp_ready`=1.
- Wrap and skip: `ptr`=3 with only requesters 1 and 3 valid. Expect grant 3, then `ptr`=0, and the next grant is 1.
- Reset in RESP: with `rsp_valid`=1, assert `reset` for one cycle. Expect `rsp_valid`=0 and `busy`=0 next cycle, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/student_or16_arbiter.sv
// Round-robin arbiter sharing one student_or16 datapath among NREQ requesters,
// with valid/ready handshakes on every requester and on the result port.

module student_or (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(~i_a & ~i_b);
endmodule

module student_or16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    for (genvar g = 0; g < 16; g++) begin : g_bit
        student_or u_or (.i_a(i_a[g]), .i_b(i_b[g]), .o_y(o_y[g]));
    end
endmodule

module student_or8way (
    input  logic [7:0] i_in,
    output logic       o_out
);
    logic [3:0] w_l1;
    logic [1:0] w_l2;

    for (genvar g = 0; g < 4; g++) begin : g_l1
        student_or u_or (.i_a(i_in[2*g]), .i_b(i_in[2*g+1]), .o_y(w_l1[g]));
    end
    for (genvar g = 0; g < 2; g++) begin : g_l2
        student_or u_or (.i_a(w_l1[2*g]), .i_b(w_l1[2*g+1]), .o_y(w_l2[g]));
    end
    student_or u_l3 (.i_a(w_l2[0]), .i_b(w_l2[1]), .o_y(o_out));
endmodule

module student_or16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_nz,
    output logic                 busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic [IDW-1:0]  r_id;
    logic [15:0]     r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_nz;

    logic            w_found;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_grant_id;
    logic            w_accept;
    logic [15:0]     w_or;
    logic            w_nz_lo;
    logic            w_nz_hi;
    logic            w_nz;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch is inferred.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_ptr + IDW'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    // Reset wins over a handshake presented in the same cycle.
    assign w_accept = (r_state == S_IDLE) && w_found && !reset;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant_id] = 1'b1;
    end

    student_or16   u_or16  (.i_a(r_a), .i_b(r_b), .o_y(w_or));
    student_or8way u_nz_lo (.i_in(w_or[7:0]),  .o_out(w_nz_lo));
    student_or8way u_nz_hi (.i_in(w_or[15:8]), .o_out(w_nz_hi));
    student_or     u_nz    (.i_a(w_nz_lo), .i_b(w_nz_hi), .o_y(w_nz));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rsp_nz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[16*w_grant_id +: 16];
                        r_b     <= req_b[16*w_grant_id +: 16];
                        r_id    <= w_grant_id;
                        r_ptr   <= w_grant_id + IDW'(1);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data <= w_or;
                    r_rsp_nz   <= w_nz;
                    r_rsp_id   <= r_id;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_nz    = r_rsp_nz;
endmodule

// File: tb/tb_student_or16_arbiter.sv
// Directed bench for student_or16_arbiter (NREQ=4): table of single transactions
// followed by hand-written round-robin, backpressure, wrap and reset sequences.

module tb_student_or16_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_nz;
    logic        busy;

    int checks = 0;
    int errors = 0;

    student_or16_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_nz(rsp_nz), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [15:0] exp_data;
        logic        exp_nz;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One transaction from IDLE with rsp_ready high; operands are scrambled
    // after the accept edge so a late sample would corrupt the result.
    task automatic do_txn(input vec_t v);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        check("txn_grant", req_ready, v.exp_ready);
        check("txn_idle_busy", busy, 1'b0);
        tick();
        req_valid = '0;
        req_a     = ~v.a;
        req_b     = ~v.b;
        #1;
        check("txn_exec_busy", busy, 1'b1);
        check("txn_exec_valid", rsp_valid, 1'b0);
        check("txn_exec_ready", req_ready, 4'b0000);
        tick();
        #1;
        check("txn_rsp_valid", rsp_valid, 1'b1);
        check("txn_rsp_data", rsp_data, v.exp_data);
        check("txn_rsp_id", rsp_id, v.exp_id);
        check("txn_rsp_nz", rsp_nz, v.exp_nz);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lanes: [63:48]=req3, [47:32]=req2, [31:16]=req1, [15:0]=req0.
        vecs[0] = '{4'b0100, 64'h1111_00F0_2222_4444, 64'h8888_0F00_0000_0000, 4'b0100, 2'd2, 16'h0FF0, 1'b1};
        vecs[1] = '{4'b0001, 64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0000_0000, 4'b0001, 2'd0, 16'h0000, 1'b0};
        vecs[2] = '{4'b1001, 64'h8000_0000_0000_1234, 64'h0001_0000_0000_0001, 4'b1000, 2'd3, 16'h8001, 1'b1};
        vecs[3] = '{4'b1111, 64'h0000_0000_0000_A5A5, 64'h0000_FFFF_0000_5A5A, 4'b0001, 2'd0, 16'hFFFF, 1'b1};
        vecs[4] = '{4'b0001, 64'h0000_0000_00FF_0100, 64'h0000_0000_0000_0000, 4'b0001, 2'd0, 16'h0100, 1'b1};
        vecs[5] = '{4'b1000, 64'h0000_0000_0000_0000, 64'h0080_0000_FFFF_0000, 4'b1000, 2'd3, 16'h0080, 1'b1};

        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        #1;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_id", rsp_id, 2'd0);
        check("rst_rsp_nz", rsp_nz, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset     = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Round-robin: all valid, pointer starts at 0; grants every 3 cycles.
        req_valid = 4'b1111;
        req_a     = 64'h0004_0003_0002_0001;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            #1;
            check("rr_req_ready", req_ready, exp_rdy);
            tick();
        end

        // Backpressure on requester 2 (pointer is 1 here).
        req_valid = 4'b0100;
        req_a     = 64'h0000_1200_0000_0000;
        req_b     = 64'h0000_0034_0000_0000;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1010;
        req_a     = 64'h00FF_FFFF_0003_FFFF;
        req_b     = 64'hFF00_FFFF_0000_FFFF;
        #1;
        check("bp_exec_ready", req_ready, 4'b0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data", rsp_data, 16'h1234);
            check("bp_rsp_id", rsp_id, 2'd2);
            check("bp_rsp_nz", rsp_nz, 1'b1);
            check("bp_busy", busy, 1'b1);
            check("bp_req_ready", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", rsp_valid, 1'b1);
        check("bp_release_ready", req_ready, 4'b0000);
        tick();

        // Wrap and skip: pointer 3, requesters 1 and 3 valid.
        #1;
        check("wrap_grant3", req_ready, 4'b1000);
        tick();
        tick();
        #1;
        check("wrap_rsp_id", rsp_id, 2'd3);
        check("wrap_rsp_data", rsp_data, 16'hFFFF);
        tick();
        rsp_ready = 1'b0;
        #1;
        check("wrap_grant1", req_ready, 4'b0010);
        tick();
        tick();
        #1;
        check("skip_rsp_id", rsp_id, 2'd1);
        check("skip_rsp_data", rsp_data, 16'h0003);
        check("skip_rsp_valid", rsp_valid, 1'b1);

        // Reset in RESP: pointer (2 here) must return to 0.
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("rst_resp_ready", req_ready, 4'b0000);
        tick();
        reset     = 1'b0;
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        #1;
        check("rst_resp_valid", rsp_valid, 1'b0);
        check("rst_resp_busy", busy, 1'b0);
        check("rst_resp_data", rsp_data, 16'h0000);
        check("rst_resp_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        #1;
        check("rst_after_id", rsp_id, 2'd1);
        check("rst_after_valid", rsp_valid, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
